if_stage_pipe: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined MIPS CPU.
- Holds the PC and drives the instruction-memory address.
- Applies branch, jump and jr redirects, including redirects that arrive while the PC is frozen.
- Registers the fetched instruction and presents its decoded fields (opcode, rs, rt) to the hazard unit and ID stage.
- Obeys the hazard unit's PCWre and IFID_Stall, plus flush requests.

---
 rtl/if_stage_pipe.sv | 116 +++++++++++
 tb/tb_if_stage_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC and deferred redirects, and presents the decoded fields of the registered instruction.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IFID_Stall,
    input  logic        IFID_Flush,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrTarget,
    output logic [31:0] IAddr,
    input  logic [31:0] IDataIn,
    output logic [31:0] PC,
    output logic [31:0] Instr_IFID,
    output logic [31:0] PCPlus4_IFID,
    output logic        Valid_IFID,
    output logic [5:0]  Opcode_IFID,
    output logic [4:0]  RsAddr_IFID,
    output logic [4:0]  RtAddr_IFID,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
);

    logic        pendValid;
    logic [31:0] pendTarget;
    logic [31:0] pcPlus4;
    logic [31:0] rawTarget;
    logic [31:0] redirectTarget;
    logic        redirectReq;
    logic        redirectTaken;
    logic        loadIfid;
    logic [31:0] pcNext;
    logic        pendValidNext;
    logic [31:0] pendTargetNext;

    assign pcPlus4     = PC + 32'd4;
    assign redirectReq = (PCSrc != 2'd0);

    // Jump targets take their upper nibble from the delay-slot PC held in IF/ID.
    always_comb begin
        rawTarget = BranchTarget;
        case (PCSrc)
            2'd1:    rawTarget = BranchTarget;
            2'd2:    rawTarget = {PCPlus4_IFID[31:28], JumpIndex, 2'b00};
            2'd3:    rawTarget = JrTarget;
            default: rawTarget = BranchTarget;
        endcase
        redirectTarget = rawTarget & 32'hFFFF_FFFC;
    end

    // A redirect seen while the PC is frozen is parked until the first cycle PCWre allows it.
    always_comb begin
        pcNext         = PC;
        pendValidNext  = pendValid;
        pendTargetNext = pendTarget;
        redirectTaken  = 1'b0;
        if (redirectReq && PCWre) begin
            pcNext        = redirectTarget;
            pendValidNext = 1'b0;
            redirectTaken = 1'b1;
        end else if (redirectReq) begin
            pendValidNext  = 1'b1;
            pendTargetNext = redirectTarget;
        end else if (pendValid && PCWre) begin
            pcNext        = pendTarget;
            pendValidNext = 1'b0;
            redirectTaken = 1'b1;
        end else if (PCWre) begin
            pcNext = pcPlus4;
        end
    end

    assign loadIfid = !IFID_Flush && !IFID_Stall && !redirectTaken;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            PC           <= RESET_PC;
            pendValid    <= 1'b0;
            pendTarget   <= 32'd0;
            Instr_IFID   <= NOP_INSTR;
            PCPlus4_IFID <= 32'd0;
            Valid_IFID   <= 1'b0;
            FetchCount   <= 32'd0;
            StallCount   <= 32'd0;
        end else begin
            PC         <= pcNext;
            pendValid  <= pendValidNext;
            pendTarget <= pendTargetNext;
            // Flush and wrong-path fetches both leave a bubble; stall simply holds.
            if (IFID_Flush || (!IFID_Stall && redirectTaken)) begin
                Instr_IFID   <= NOP_INSTR;
                PCPlus4_IFID <= 32'd0;
                Valid_IFID   <= 1'b0;
            end else if (loadIfid) begin
                Instr_IFID   <= IDataIn;
                PCPlus4_IFID <= pcPlus4;
                Valid_IFID   <= 1'b1;
                FetchCount   <= FetchCount + 32'd1;
            end
            if (!PCWre) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end

    assign IAddr       = PC;
    assign Opcode_IFID = Instr_IFID[31:26];
    assign RsAddr_IFID = Instr_IFID[25:21];
    assign RtAddr_IFID = Instr_IFID[20:16];

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: a per-cycle reference model of the fetch stage plus
// hand-computed checkpoints along the test plan.
module tb_if_stage_pipe;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic        IFID_Stall;
    logic        IFID_Flush;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] JrTarget;
    logic [31:0] IAddr;
    logic [31:0] IDataIn;
    logic [31:0] PC;
    logic [31:0] Instr_IFID;
    logic [31:0] PCPlus4_IFID;
    logic        Valid_IFID;
    logic [5:0]  Opcode_IFID;
    logic [4:0]  RsAddr_IFID;
    logic [4:0]  RtAddr_IFID;
    logic [31:0] FetchCount;
    logic [31:0] StallCount;

    int testCount = 0;
    int failCount = 0;
    logic checkOn = 1'b0;

    logic [31:0] modelPc;
    logic        modelPend;
    logic [31:0] modelPendTarget;
    logic [31:0] modelInstr;
    logic [31:0] modelPcPlus4;
    logic        modelValid;
    logic [31:0] modelFetch;
    logic [31:0] modelStall;

    if_stage_pipe dut (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .IFID_Stall(IFID_Stall),
        .IFID_Flush(IFID_Flush), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .JumpIndex(JumpIndex), .JrTarget(JrTarget), .IAddr(IAddr), .IDataIn(IDataIn),
        .PC(PC), .Instr_IFID(Instr_IFID), .PCPlus4_IFID(PCPlus4_IFID),
        .Valid_IFID(Valid_IFID), .Opcode_IFID(Opcode_IFID), .RsAddr_IFID(RsAddr_IFID),
        .RtAddr_IFID(RtAddr_IFID), .FetchCount(FetchCount), .StallCount(StallCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction memory: word i holds 0x2000_0000 + i.
    function automatic logic [31:0] imemWord(input logic [31:0] addr);
        return 32'h2000_0000 + (addr >> 2);
    endfunction

    assign IDataIn = imemWord(IAddr);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one call per rising edge, straight from the stage's rules.
    always @(posedge CLK) begin
        logic [31:0] oldPc;
        logic [31:0] tgt;
        logic        taken;
        if (Reset) begin
            modelPc = 32'd0; modelPend = 1'b0; modelPendTarget = 32'd0;
            modelInstr = 32'd0; modelPcPlus4 = 32'd0; modelValid = 1'b0;
            modelFetch = 32'd0; modelStall = 32'd0;
        end else begin
            oldPc = modelPc;
            taken = 1'b0;
            case (PCSrc)
                2'd1:    tgt = BranchTarget;
                2'd2:    tgt = (modelPcPlus4 & 32'hF000_0000) | ({6'd0, JumpIndex} << 2);
                default: tgt = JrTarget;
            endcase
            tgt = tgt & ~32'd3;
            if (PCSrc != 2'd0 && PCWre) begin
                modelPc = tgt; modelPend = 1'b0; taken = 1'b1;
            end else if (PCSrc != 2'd0) begin
                modelPend = 1'b1; modelPendTarget = tgt;
            end else if (modelPend && PCWre) begin
                modelPc = modelPendTarget; modelPend = 1'b0; taken = 1'b1;
            end else if (PCWre) begin
                modelPc = oldPc + 32'd4;
            end
            if (IFID_Flush || (!IFID_Stall && taken)) begin
                modelInstr = 32'd0; modelPcPlus4 = 32'd0; modelValid = 1'b0;
            end else if (!IFID_Stall) begin
                modelInstr = imemWord(oldPc); modelPcPlus4 = oldPc + 32'd4; modelValid = 1'b1;
                modelFetch = modelFetch + 32'd1;
            end
            if (!PCWre) modelStall = modelStall + 32'd1;
        end
    end

    always @(negedge CLK) begin
        if (checkOn) begin
            checkOutput("IAddr", IAddr, modelPc);
            checkOutput("PC", PC, modelPc);
            checkOutput("Instr_IFID", Instr_IFID, modelInstr);
            checkOutput("PCPlus4_IFID", PCPlus4_IFID, modelPcPlus4);
            checkOutput("Valid_IFID", {31'd0, Valid_IFID}, {31'd0, modelValid});
            checkOutput("Opcode_IFID", {26'd0, Opcode_IFID}, {26'd0, modelInstr[31:26]});
            checkOutput("RsAddr_IFID", {27'd0, RsAddr_IFID}, {27'd0, modelInstr[25:21]});
            checkOutput("RtAddr_IFID", {27'd0, RtAddr_IFID}, {27'd0, modelInstr[20:16]});
            checkOutput("FetchCount", FetchCount, modelFetch);
            checkOutput("StallCount", StallCount, modelStall);
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input logic rst, input logic wre, input logic stall,
                                 input logic flush, input logic [1:0] src,
                                 input logic [31:0] bt, input logic [25:0] ji,
                                 input logic [31:0] jr);
        Reset = rst; PCWre = wre; IFID_Stall = stall; IFID_Flush = flush;
        PCSrc = src; BranchTarget = bt; JumpIndex = ji; JrTarget = jr;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1; PCWre = 1'b1; IFID_Stall = 1'b0; IFID_Flush = 1'b0;
        PCSrc = 2'd0; BranchTarget = 32'd0; JumpIndex = 26'd0; JrTarget = 32'd0;
        @(negedge CLK);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        checkOn = 1'b1;
        checkOutput("reset PC", PC, 32'h0);
        checkOutput("reset Valid", {31'd0, Valid_IFID}, 32'd0);
        checkOutput("reset Instr", Instr_IFID, 32'h0);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
            checkOutput("free PC", PC, 32'(4 * i));
            checkOutput("free Instr", Instr_IFID, 32'h2000_0000 + 32'(i - 1));
        end
        checkOutput("free FetchCount", FetchCount, 32'd4);

        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("loaduse PC", PC, 32'h10);
        checkOutput("loaduse Instr", Instr_IFID, 32'h2000_0003);
        checkOutput("loaduse StallCount", StallCount, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("after stall PC", PC, 32'h14);
        checkOutput("after stall Instr", Instr_IFID, 32'h2000_0004);

        applyStimulus(0, 1, 0, 0, 1, 32'h40, 0, 0);
        checkOutput("branch PC", PC, 32'h40);
        checkOutput("branch bubble Valid", {31'd0, Valid_IFID}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("branch target Instr", Instr_IFID, 32'h2000_0010);

        applyStimulus(0, 1, 0, 0, 1, 32'h1000_000C, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("pre-jump PCPlus4", PCPlus4_IFID, 32'h1000_0010);
        applyStimulus(0, 1, 0, 0, 2, 0, 26'h000_0020, 0);
        checkOutput("jump PC", PC, 32'h1000_0080);
        applyStimulus(0, 1, 0, 0, 3, 0, 0, 32'h0000_0107);
        checkOutput("jr PC", PC, 32'h0000_0104);

        applyStimulus(0, 0, 1, 0, 1, 32'h80, 0, 0);
        checkOutput("deferred hold PC", PC, 32'h104);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("deferred hold PC 2", PC, 32'h104);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("deferred PC", PC, 32'h80);
        checkOutput("deferred bubble", {31'd0, Valid_IFID}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("deferred cleared PC", PC, 32'h84);
        checkOutput("deferred Instr", Instr_IFID, 32'h2000_0020);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("frozen reload Instr", Instr_IFID, 32'h2000_0021);
        applyStimulus(0, 0, 1, 0, 3, 0, 0, 32'h200);
        applyStimulus(0, 1, 0, 0, 1, 32'h300, 0, 0);
        checkOutput("supersede PC", PC, 32'h300);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("advance+hold PC", PC, 32'h308);
        checkOutput("advance+hold Instr", Instr_IFID, 32'h2000_00C0);

        applyStimulus(0, 1, 0, 0, 3, 0, 0, 32'hFFFF_FFFE);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap PC", PC, 32'h0);
        checkOutput("wrap Instr", Instr_IFID, 32'h5FFF_FFFF);
        checkOutput("wrap PCPlus4", PCPlus4_IFID, 32'h0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("flush beats stall", {31'd0, Valid_IFID}, 32'd0);
        applyStimulus(0, 0, 1, 0, 1, 32'h500, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("midstall reset PC", PC, 32'h0);
        checkOutput("midstall reset StallCount", StallCount, 32'd0);
        checkOutput("midstall reset FetchCount", FetchCount, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("pending cleared PC", PC, 32'h4);
        checkOutput("post reset Instr", Instr_IFID, 32'h2000_0000);

        checkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
